// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Brief    : funct3 encodings, FSM state type and access-legality check.
// Revision : 1.0
// ============================================================================
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  // Stores allow only B/H/W; loads additionally allow the unsigned B/H forms.
  function automatic logic access_err(input logic       we,
                                      input logic [2:0] funct3,
                                      input logic [1:0] offset);
    logic illegal;
    logic misaligned;
    if (we)
      illegal = (funct3 != F3_B) && (funct3 != F3_H) && (funct3 != F3_W);
    else
      illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    misaligned = ((funct3[1:0] == 2'b01) && offset[0]) ||
                 ((funct3[1:0] == 2'b10) && (offset != 2'b00));
    return illegal || misaligned;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_if
// Brief    : Core request/response and data-memory signals of the LSU.
// Revision : 1.0
// ============================================================================
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  // Environment side: the core plus the data memory.
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_a, mem_we, mem_wd
  );

  // The load/store unit itself.
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_a, mem_we, mem_wd
  );
endinterface
`default_nettype wire

// File: rtl/lsu_lane.sv
`default_nettype none
// ============================================================================
// Module   : lsu_lane
// Brief    : Byte/halfword lane merge for stores and load extraction/extension.
// Revision : 1.0
// ============================================================================
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] store_word,
  output logic [31:0] load_val
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = word[7:0];
    case (offset)
      2'd0:    w_byte = word[7:0];
      2'd1:    w_byte = word[15:8];
      2'd2:    w_byte = word[23:16];
      default: w_byte = word[31:24];
    endcase
    w_half = offset[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    load_val = '0;
    case (funct3)
      F3_B:    load_val = {{24{w_byte[7]}}, w_byte};
      F3_H:    load_val = {{16{w_half[15]}}, w_half};
      F3_W:    load_val = word;
      F3_BU:   load_val = {24'd0, w_byte};
      F3_HU:   load_val = {16'd0, w_half};
      default: load_val = '0;
    endcase
  end

  // A word store ignores the old contents entirely.
  always_comb begin
    store_word = wdata;
    case (funct3)
      F3_B: begin
        store_word = word;
        case (offset)
          2'd0:    store_word[7:0]   = wdata[7:0];
          2'd1:    store_word[15:8]  = wdata[7:0];
          2'd2:    store_word[23:16] = wdata[7:0];
          default: store_word[31:24] = wdata[7:0];
        endcase
      end
      F3_H: store_word = offset[1] ? {wdata[15:0], word[15:0]}
                                   : {word[31:16], wdata[15:0]};
      default: store_word = wdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : Multicycle RV32I load/store unit with read-modify-write sub-word stores.
// Revision : 1.0
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  load_store_unit_if.slave bus
);

  lsu_state_t  r_state;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_req_err;
  logic [31:0] w_store_word;
  logic [31:0] w_load_val;
  logic        w_mem_phase;

  assign w_req_err = access_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_we     <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_we     <= bus.req_we;
            r_funct3 <= bus.req_funct3;
            r_addr   <= bus.req_addr;
            r_wdata  <= bus.req_wdata;
            r_err    <= w_req_err;
            // Only a full-word store can skip the read of the old word.
            if (w_req_err)
              r_state <= RESP;
            else if (bus.req_we && (bus.req_funct3 == F3_W))
              r_state <= WRITE;
            else
              r_state <= READ;
          end
        end
        READ: begin
          r_rdata <= bus.mem_rd;
          r_state <= r_we ? WRITE : RESP;
        end
        WRITE:   r_state <= RESP;
        default: r_state <= IDLE;
      endcase
    end
  end

  lsu_lane u_lane (
    .offset     (r_addr[1:0]),
    .funct3     (r_funct3),
    .word       (r_rdata),
    .wdata      (r_wdata),
    .store_word (w_store_word),
    .load_val   (w_load_val)
  );

  // Every output is forced low while reset is held, so an interrupted write never lands.
  assign w_mem_phase    = ((r_state == READ) || (r_state == WRITE)) && !reset;
  assign bus.req_ready  = (r_state == IDLE) && !reset;
  assign bus.mem_a      = w_mem_phase ? {r_addr[31:2], 2'b00} : 32'd0;
  assign bus.mem_we     = (r_state == WRITE) && !reset;
  assign bus.mem_wd     = bus.mem_we ? w_store_word : 32'd0;
  assign bus.resp_valid = (r_state == RESP) && !reset;
  assign bus.resp_err   = bus.resp_valid && r_err;
  assign bus.resp_rdata = (bus.resp_valid && !r_we && !r_err) ? w_load_val : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Directed self-checking bench for load_store_unit with a word memory model.
// Revision : 1.0
// ============================================================================
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [0:63];
  logic        init_req;
  logic [5:0]  init_idx;
  logic [31:0] init_val;

  assign bus.mem_rd = mem[bus.mem_a[7:2]];

  always @(posedge clk) begin
    if (init_req)
      mem[init_idx] <= init_val;
    else if (bus.mem_we)
      mem[bus.mem_a[7:2]] <= bus.mem_wd;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic init_word(input logic [5:0] idx, input logic [31:0] val);
    init_req = 1'b1;
    init_idx = idx;
    init_val = val;
    @(posedge clk); #1;
    init_req = 1'b0;
  endtask

  // Issues one request and records what the DUT does over the following six cycles.
  task automatic run_req(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int resp_cyc, output logic [31:0] rdata, output logic err,
                         output int we_cnt, output logic [31:0] we_addr,
                         output logic [31:0] we_data, output int we_cyc);
    resp_cyc = -1; rdata = '0; err = 1'b0;
    we_cnt = 0; we_addr = '0; we_data = '0; we_cyc = -1;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    for (int c = 0; c < 6; c++) begin
      if (bus.mem_we) begin
        we_cnt++; we_addr = bus.mem_a; we_data = bus.mem_wd; we_cyc = c;
      end
      if (bus.resp_valid && resp_cyc < 0) begin
        resp_cyc = c; rdata = bus.resp_rdata; err = bus.resp_err;
      end
      @(posedge clk); #1;
      if (c == 0) bus.req_valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.req_ready !== 1'b0) begin
      bad++; $display("FAIL reset_ready: got %b want 0", bus.req_ready);
    end
    total++;
    if ({bus.resp_valid, bus.resp_err, bus.mem_we} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got %b want 000", {bus.resp_valid, bus.resp_err, bus.mem_we});
    end
    total++;
    if ({bus.mem_a, bus.mem_wd, bus.resp_rdata} !== 96'd0) begin
      bad++; $display("FAIL reset_data: got %h want 0", {bus.mem_a, bus.mem_wd, bus.resp_rdata});
    end
    bus.req_valid = 1'b0;
    reset = 1'b0;
    #1;
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release_ready: got %b want 1", bus.req_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_loads;
    logic [2:0]  f3s  [3] = '{F3_B, F3_BU, F3_W};
    logic [31:0] adrs [3] = '{32'h11, 32'h13, 32'h10};
    logic [31:0] exps [3] = '{32'hFFFF_FFAA, 32'h0000_0088, 32'h8899_AABB};
    int rc, wc, wy; logic [31:0] rd, wa, wd; logic er;
    for (int i = 0; i < 3; i++) begin
      init_word(6'd4, 32'h8899_AABB);
      total++;
      if (bus.req_ready !== 1'b1) begin
        bad++; $display("FAIL load%0d_ready: got %b want 1", i, bus.req_ready);
      end
      run_req(1'b0, f3s[i], adrs[i], 32'hDEAD_BEEF, rc, rd, er, wc, wa, wd, wy);
      total++;
      if (rc !== 2) begin bad++; $display("FAIL load%0d_resp_cycle: got %0d want 2", i, rc); end
      total++;
      if (rd !== exps[i]) begin bad++; $display("FAIL load%0d_rdata: got %h want %h", i, rd, exps[i]); end
      total++;
      if ({er, wc[3:0]} !== 5'd0) begin bad++; $display("FAIL load%0d_err_we: got err=%b writes=%0d want 0/0", i, er, wc); end
    end
  endtask

  task automatic test_sub_stores;
    int rc, wc, wy; logic [31:0] rd, wa, wd; logic er;
    init_word(6'd4, 32'h8899_AABB);
    run_req(1'b1, F3_B, 32'h12, 32'h1234_5677, rc, rd, er, wc, wa, wd, wy);
    total++;
    if (wc !== 1 || wy !== 2) begin bad++; $display("FAIL sb_write_timing: got count=%0d cycle=%0d want 1/2", wc, wy); end
    total++;
    if (wa !== 32'h10) begin bad++; $display("FAIL sb_mem_a: got %h want 00000010", wa); end
    total++;
    if (wd !== 32'h8877_AABB) begin bad++; $display("FAIL sb_mem_wd: got %h want 8877aabb", wd); end
    total++;
    if (rc !== 3 || er !== 1'b0 || rd !== 32'd0) begin
      bad++; $display("FAIL sb_resp: got cycle=%0d err=%b rdata=%h want 3/0/0", rc, er, rd);
    end
    total++;
    if (mem[4] !== 32'h8877_AABB) begin bad++; $display("FAIL sb_mem_word: got %h want 8877aabb", mem[4]); end

    init_word(6'd4, 32'h8899_AABB);
    run_req(1'b1, F3_H, 32'h12, 32'h0000_CAFE, rc, rd, er, wc, wa, wd, wy);
    total++;
    if (rc !== 3 || wy !== 2) begin bad++; $display("FAIL sh_timing: got resp=%0d write=%0d want 3/2", rc, wy); end
    total++;
    if (mem[4] !== 32'hCAFE_AABB) begin bad++; $display("FAIL sh_mem_word: got %h want cafeaabb", mem[4]); end
    run_req(1'b0, F3_H, 32'h12, 32'd0, rc, rd, er, wc, wa, wd, wy);
    total++;
    if (rd !== 32'hFFFF_CAFE || rc !== 2) begin bad++; $display("FAIL lh_after_sh: got %h cycle=%0d want ffffcafe/2", rd, rc); end
    run_req(1'b0, F3_HU, 32'h12, 32'd0, rc, rd, er, wc, wa, wd, wy);
    total++;
    if (rd !== 32'h0000_CAFE) begin bad++; $display("FAIL lhu_after_sh: got %h want 0000cafe", rd); end
  endtask

  task automatic test_errors;
    logic        wes  [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s  [3] = '{F3_W, F3_H, 3'b011};
    logic [31:0] adrs [3] = '{32'h16, 32'h13, 32'h10};
    int rc, wc, wy; logic [31:0] rd, wa, wd; logic er;
    for (int i = 0; i < 3; i++) begin
      init_word(6'd4, 32'h8899_AABB);
      run_req(wes[i], f3s[i], adrs[i], 32'hFFFF_FFFF, rc, rd, er, wc, wa, wd, wy);
      total++;
      if (rc !== 1) begin bad++; $display("FAIL err%0d_resp_cycle: got %0d want 1", i, rc); end
      total++;
      if (er !== 1'b1 || rd !== 32'd0) begin bad++; $display("FAIL err%0d_resp: got err=%b rdata=%h want 1/0", i, er, rd); end
      total++;
      if (wc !== 0) begin bad++; $display("FAIL err%0d_no_write: got %0d writes want 0", i, wc); end
    end
    total++;
    if (mem[4] !== 32'h8899_AABB) begin bad++; $display("FAIL err_mem_word: got %h want 8899aabb", mem[4]); end
  endtask

  task automatic test_reset_in_write;
    int resp_seen;
    init_word(6'd4, 32'h8899_AABB);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_B;
    bus.req_addr   = 32'h10;
    bus.req_wdata  = 32'h0000_0011;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    total++;
    if (bus.mem_a !== 32'h10 || bus.mem_we !== 1'b0) begin
      bad++; $display("FAIL rw_read_phase: got a=%h we=%b want 00000010/0", bus.mem_a, bus.mem_we);
    end
    @(posedge clk); #1;
    total++;
    if (bus.mem_we !== 1'b1 || bus.mem_wd !== 32'h8899_AA11) begin
      bad++; $display("FAIL rw_write_phase: got we=%b wd=%h want 1/8899aa11", bus.mem_we, bus.mem_wd);
    end
    reset = 1'b1;
    #1;
    total++;
    if (bus.mem_we !== 1'b0 || bus.req_ready !== 1'b0) begin
      bad++; $display("FAIL rw_gated: got we=%b ready=%b want 0/0", bus.mem_we, bus.req_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    total++;
    if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rw_ready_after: got %b want 1", bus.req_ready); end
    resp_seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus.resp_valid) resp_seen++;
      @(posedge clk); #1;
    end
    total++;
    if (resp_seen !== 0) begin bad++; $display("FAIL rw_no_resp: got %0d responses want 0", resp_seen); end
    total++;
    if (mem[4] !== 32'h8899_AABB) begin bad++; $display("FAIL rw_mem_word: got %h want 8899aabb", mem[4]); end
  endtask

  task automatic test_back_to_back;
    logic [5:0] exp_ready = 6'b001001;
    logic [5:0] exp_we    = 6'b010010;
    logic [5:0] exp_resp  = 6'b100100;
    logic [31:0] exp_a, exp_d;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'h1111_2222;
    for (int c = 0; c < 6; c++) begin
      total++;
      if ({bus.req_ready, bus.mem_we, bus.resp_valid} !== {exp_ready[c], exp_we[c], exp_resp[c]}) begin
        bad++;
        $display("FAIL b2b_cycle%0d: got ready/we/resp=%b%b%b want %b%b%b", c,
                 bus.req_ready, bus.mem_we, bus.resp_valid, exp_ready[c], exp_we[c], exp_resp[c]);
      end
      if (exp_we[c]) begin
        exp_a = (c < 3) ? 32'h20 : 32'h24;
        exp_d = (c < 3) ? 32'h1111_2222 : 32'h3333_4444;
        total++;
        if (bus.mem_a !== exp_a || bus.mem_wd !== exp_d) begin
          bad++; $display("FAIL b2b_write%0d: got a=%h wd=%h want %h/%h", c, bus.mem_a, bus.mem_wd, exp_a, exp_d);
        end
      end
      @(posedge clk); #1;
      if (c == 0) begin
        bus.req_addr  = 32'h24;
        bus.req_wdata = 32'h3333_4444;
      end
      if (c == 3) bus.req_valid = 1'b0;
    end
    total++;
    if (mem[8] !== 32'h1111_2222 || mem[9] !== 32'h3333_4444) begin
      bad++; $display("FAIL b2b_mem: got %h %h want 11112222 33334444", mem[8], mem[9]);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    init_req = 1'b0;
    init_idx = '0;
    init_val = '0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    test_loads;
    test_sub_stores;
    test_errors;
    test_reset_in_write;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side load/store unit between the multicycle RV32I core and the word-addressed data memory (combinational read, word-wide synchronous write). It accepts one load or store per request, performs sub-word stores as read-modify-write, and returns extracted, sign- or zero-extended load data. It also flags misaligned or illegal accesses before any memory access is made.

## Interface
- No parameters; data and address width fixed at 32.
- `clk`  in  1  system clock, all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  core presents a request.
- `req_ready`  out  1  unit can accept; transfer occurs when `req_valid & req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data (low byte/halfword used for SB/SH).
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  load result; 0 for stores and errors.
- `resp_err`  out  1  misaligned or illegal funct3; valid with `resp_valid`.
- `mem_a`  out  32  word address to memory, bits [1:0] always 0.
- `mem_we`  out  1  memory write enable.
- `mem_wd`  out  32  memory write data.
- `mem_rd`  in  32  memory read data (combinational from `mem_a`).

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: `req_ready`=1. On a transfer, latch we, funct3, addr, wdata.
  - Error: illegal funct3 (loads 011/110/111; stores 1xx/011) or misaligned (H: addr[0]≠0; W: addr[1:0]≠0). Go to RESP with err=1 and no memory access.
  - Load: go to READ.
  - SW: go to WRITE.
  - SB/SH: go to READ.
- READ: `mem_a`={addr[31:2],2'b00}. Register `mem_rd` into rdata_q. Load goes to RESP; SB/SH goes to WRITE.
- WRITE: `mem_a` as in READ, `mem_we`=1.
  - SW: `mem_wd`=wdata.
  - SB: rdata_q with byte lane addr[1:0] replaced by wdata[7:0].
  - SH: rdata_q with halfword lane addr[1] replaced by wdata[15:0].
  - Next state RESP.
- RESP: `resp_valid`=1 for one cycle, then IDLE.
  - Load data: lane little-endian (byte k = bits 8k+7:8k). LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
- No response backpressure; the core must accept `resp_valid` in the cycle it is asserted.
- Outside READ/WRITE, `mem_a`=0 and `mem_wd`=0. `mem_we` is asserted only in WRITE.

## Timing
- Cycle 0 = request accepted.
  - Load: READ in cycle 1, `resp_valid` in cycle 2.
  - SW: write in cycle 1, resp in cycle 2.
  - SB/SH: read in cycle 1, write in cycle 2, resp in cycle 3.
  - Error: resp in cycle 1.
- `req_ready`=(state==IDLE)&~reset. Back-to-back requests resume in the cycle after RESP.
- Reset: state→IDLE and all registers cleared. While reset is high, every output is 0, including `req_ready`.
- Reset during WRITE: `mem_we` is gated by ~reset, so no write occurs and the memory word is unchanged. Reset during READ/RESP aborts the access with no response.
- The memory write lands on the rising edge that ends the WRITE cycle. A load issued afterward observes it.

## Structure
- Package `lsu_pkg` holds:
  - funct3 localparams `F3_B`=3'b000, `F3_H`=3'b001, `F3_W`=3'b010, `F3_BU`=3'b100, `F3_HU`=3'b101.
  - State enum `lsu_state_t` {IDLE, READ, WRITE, RESP}.
- One combinational sub-module `lsu_lane`: given offset, funct3, word and store data, produce the merged store word and the extended load value. The FSM and registers live in `load_store_unit`.

## Test plan
Initialize the memory word at 0x10 to 0x8899AABB before each scenario.
- LB 0x11 → resp cycle 2, rdata 0xFFFFFFAA, err 0. LBU 0x13 → 0x00000088. LW 0x10 → 0x8899AABB.
- SB 0x12, wdata 0x12345677 → `mem_we` high only in cycle 2 with `mem_a`=0x10, `mem_wd`=0x8877AABB. Resp in cycle 3.
- SH 0x12, wdata 0x0000CAFE → word becomes 0xCAFEAABB. A following LH 0x12 → 0xFFFFCAFE; LHU 0x12 → 0x0000CAFE.
- LW 0x16, SH 0x13, and funct3 011 load → resp cycle 1 with err=1, rdata 0, `mem_we` never asserted.
- SB 0x10 with reset asserted in its WRITE cycle → no write, word stays 0x8899AABB. No `resp_valid`; `req_ready`=1 the first cycle after reset drops.
- `req_valid` held high with two SW requests → `req_ready` low during WRITE/RESP. Second request accepted in the cycle after the first response; both words written in order.
